// File: rtl/dec_scan_seq.sv
// Round-robin select/enable sequencer for a 3-to-8 decoder, with a one-cycle blanking guard before each channel.
// Latency: start -> guard after 1 edge, enb_ low after 2 edges; no flow control, start ignored while busy.
module dec_scan_seq #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               start,
    input  logic               stop,
    input  logic [7:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               enb_,
    output logic               busy,
    output logic               frame_done
);

    typedef enum logic [1:0] {IDLE, GUARD, ACTIVE} state_t;

    state_t             state, state_nxt;
    logic [7:0]         mask_q, mask_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic               stop_q, stop_nxt;
    logic [2:0]         sel_nxt;
    logic               enb_nxt, busy_nxt, fd_nxt;

    function automatic logic [2:0] lowest(input logic [7:0] m);
        lowest = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) lowest = 3'(i);
    endfunction

    // Returns {found, index} of the lowest set bit strictly above cur.
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
        next_above = 4'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i] && (i > int'(cur))) next_above = {1'b1, 3'(i)};
    endfunction

    always_comb begin
        logic [3:0] nxt;
        state_nxt = state;
        mask_nxt  = mask_q;
        cnt_nxt   = cnt;
        stop_nxt  = stop_q;
        sel_nxt   = sel;
        enb_nxt   = 1'b1;
        fd_nxt    = 1'b0;
        nxt       = next_above(mask_q, sel);
        case (state)
            IDLE: begin
                if (start && !stop && (ch_mask != 8'd0)) begin
                    state_nxt = GUARD;
                    mask_nxt  = ch_mask;
                    sel_nxt   = lowest(ch_mask);
                end
            end
            GUARD: begin
                state_nxt = ACTIVE;
                cnt_nxt   = dwell;
                enb_nxt   = 1'b0;
                stop_nxt  = stop_q | stop;
            end
            ACTIVE: begin
                stop_nxt = stop_q | stop;
                if (cnt != '0) begin
                    cnt_nxt = cnt - DWELL_W'(1);
                    enb_nxt = 1'b0;
                end else if (stop_q || stop) begin
                    state_nxt = IDLE;
                    stop_nxt  = 1'b0;
                end else if (nxt[3]) begin
                    state_nxt = GUARD;
                    sel_nxt   = nxt[2:0];
                end else begin
                    // Frame wrap: the live mask is only looked at here.
                    fd_nxt   = 1'b1;
                    mask_nxt = ch_mask;
                    if (ch_mask != 8'd0) begin
                        state_nxt = GUARD;
                        sel_nxt   = lowest(ch_mask);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= IDLE;
            mask_q     <= 8'd0;
            cnt        <= '0;
            stop_q     <= 1'b0;
            sel        <= 3'd0;
            enb_       <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            mask_q     <= mask_nxt;
            cnt        <= cnt_nxt;
            stop_q     <= stop_nxt;
            sel        <= sel_nxt;
            enb_       <= enb_nxt;
            busy       <= busy_nxt;
            frame_done <= fd_nxt;
        end
    end

endmodule

// File: tb/tb_dec_scan_seq.sv
// Bench for dec_scan_seq: directed scenarios plus random traffic against a slot-level reference model.
module tb_dec_scan_seq;

    logic       clk = 1'b0;
    logic       rst_;
    logic       start, stop;
    logic [7:0] ch_mask;
    logic [7:0] dwell;
    logic [2:0] sel;
    logic       enb_, busy, frame_done;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    bit       m_busy, m_guard, m_stop, m_fd;
    int       m_left, m_sel;
    bit [7:0] m_mask;

    dec_scan_seq #(.DWELL_W(8)) dut (
        .clk(clk), .rst_(rst_), .start(start), .stop(stop), .ch_mask(ch_mask),
        .dwell(dwell), .sel(sel), .enb_(enb_), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    function automatic int lowest_ch(input bit [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic int next_ch(input bit [7:0] m, input int cur);
        for (int i = cur + 1; i < 8; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_guard = 0; m_stop = 0; m_fd = 0;
        m_left = 0; m_sel = 0; m_mask = 8'd0;
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_step();
        bit stop_seen;
        int n;
        m_fd = 0;
        stop_seen = m_stop || stop;
        if (!m_busy) begin
            if (start && !stop && ch_mask != 8'd0) begin
                m_busy = 1; m_guard = 1; m_stop = 0;
                m_mask = ch_mask;
                m_sel  = lowest_ch(ch_mask);
            end
        end else if (m_guard) begin
            m_guard = 0;
            m_left  = int'(dwell) + 1;
            m_stop  = stop_seen;
        end else begin
            m_left--;
            m_stop = stop_seen;
            if (m_left == 0) begin
                if (stop_seen) begin
                    m_busy = 0; m_stop = 0;
                end else begin
                    n = next_ch(m_mask, m_sel);
                    if (n >= 0) begin
                        m_sel = n; m_guard = 1;
                    end else begin
                        m_fd   = 1;
                        m_mask = ch_mask;
                        if (ch_mask == 8'd0) m_busy = 0;
                        else begin
                            m_sel = lowest_ch(ch_mask); m_guard = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        logic [2:0] psel;
        psel = sel;
        @(posedge clk);
        model_step();
        #1;
        check("sel", 32'(sel), 32'(m_sel));
        check("enb_", 32'(enb_), 32'(!(m_busy && !m_guard)));
        check("busy", 32'(busy), 32'(m_busy));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        if (enb_ == 1'b0) check("sel_stable_while_enabled", 32'(sel), 32'(psel));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    initial begin
        bit found;
        rst_ = 1'b1; start = 1'b0; stop = 1'b0; ch_mask = 8'd0; dwell = 8'd0;
        model_reset();
        #1 rst_ = 1'b0;
        #1;
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_enb_", 32'(enb_), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk) rst_ = 1'b1;

        // full mask, single-cycle dwell, two frames then stop
        ch_mask = 8'hFF; dwell = 8'd0;
        pulse_start();
        run(34);
        pulse_stop();
        run(20);

        // sparse mask 2,5,7 with dwell 3; then stop in 2nd active cycle of channel 5
        ch_mask = 8'b1010_0100; dwell = 8'd3;
        pulse_start();
        run(30);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (sel == 3'd5 && enb_ == 1'b0) found = 1;
        end
        check("found_sel5_active", 32'(found), 32'd1);
        tick();
        pulse_stop();
        run(15);
        check("idle_after_stop", 32'(busy), 32'd0);

        // start with empty mask; start together with stop
        ch_mask = 8'h00;
        pulse_start();
        run(3);
        ch_mask = 8'hFF; start = 1'b1; stop = 1'b1; tick();
        start = 1'b0; stop = 1'b0;
        run(5);

        // mask emptied mid-frame: frame finishes, then idle
        ch_mask = 8'h0F; dwell = 8'd1;
        pulse_start();
        run(4);
        ch_mask = 8'h00;
        run(25);

        // single channel at maximum dwell
        ch_mask = 8'h10; dwell = 8'hFF;
        pulse_start();
        run(520);
        pulse_stop();
        run(260);

        // asynchronous reset in the middle of an active dwell
        ch_mask = 8'hFF; dwell = 8'd10;
        pulse_start();
        run(5);
        check("pre_reset_active", 32'(enb_), 32'd0);
        #2 rst_ = 1'b0;
        #1;
        check("midscan_rst_enb_", 32'(enb_), 32'd1);
        check("midscan_rst_sel", 32'(sel), 32'd0);
        check("midscan_rst_busy", 32'(busy), 32'd0);
        check("midscan_rst_frame_done", 32'(frame_done), 32'd0);
        model_reset();
        @(negedge clk) rst_ = 1'b1;
        run(3);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0)
                ch_mask = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            dwell = 8'($urandom_range(0, 4));
            tick();
        end
        start = 1'b0; stop = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
